uart_rx_ram_top: RTL

//  Receive side of the board UART link: 8N1 serial receiver plus an on-chip capture RAM

---
 rtl/uart_rx_ram_pkg.sv | 21 ++
 rtl/uart_rx_ram_rx.sv | 126 ++++++++++++
 rtl/uart_rx_ram_top.sv | 98 +++++++++
 3 files changed

// File: rtl/uart_rx_ram_pkg.sv
// Shared definitions for the UART capture path: receiver FSM states, 8N1 line levels
// and default link parameters.
package uart_rx_ram_pkg;

  localparam int DEF_CLKS_PER_BIT = 5208;
  localparam int DEF_WIDTH        = 8;
  localparam int DEF_DEPTH        = 84;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ram_rx.sv
// 8N1 serial receiver: two-flop synchronizer, bit-timing FSM and LSB-first shift register.
// Produces the last good byte plus one-cycle valid / framing-error pulses.
module uart_rx_ram_rx
  import uart_rx_ram_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int WIDTH        = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             frame_err_o,
  output logic             rx_busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic             rx_meta_q, rx_s_q;
  rx_state_e        state_q, state_d;
  logic [CW-1:0]    clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;

  // The line is asynchronous; the FSM only ever looks at the second flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= LINE_IDLE;
      rx_s_q    <= LINE_IDLE;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RX_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Start is checked at half a bit, every later sample one full bit on, landing mid-bit.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        if (rx_s_q == START_LVL) state_d = RX_START;
      end
      RX_START: begin
        if (clk_cnt_q == HALF_CNT) begin
          clk_cnt_d = '0;
          state_d   = (rx_s_q == START_LVL) ? RX_DATA : RX_IDLE;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[WIDTH-1:1]};
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d = '0;
          if (rx_s_q == STOP_LVL) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
            state_d    = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        clk_cnt_d = '0;
        if (rx_s_q == LINE_IDLE) state_d = RX_IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = RX_IDLE;
      end
    endcase
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
  assign rx_busy_o   = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_rx_ram_top.sv
// UART receive capture: every good byte is appended to an on-chip RAM that the host
// reads back by address. Writes stop at full; later bytes only raise the sticky overflow.
module uart_rx_ram_top
  import uart_rx_ram_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter  int WIDTH        = DEF_WIDTH,
  parameter  int DEPTH        = DEF_DEPTH,
  localparam int ADDR         = $clog2(DEPTH),
  localparam int CNT          = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_in_i,
  input  logic             clr_i,
  input  logic [ADDR-1:0]  rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             frame_err_o,
  output logic             rx_busy_o,
  output logic [CNT-1:0]   byte_cnt_o,
  output logic             full_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;

  uart_rx_ram_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .WIDTH        (WIDTH)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_in_i),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .frame_err_o (frame_err_o),
    .rx_busy_o   (rx_busy_o)
  );

  logic [WIDTH-1:0] ram_q [DEPTH];
  // The write pointer doubles as the byte count; it is wide enough to reach DEPTH.
  logic [CNT-1:0]   wr_ptr_q, wr_ptr_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             full;
  logic             wr_en;

  assign full = (wr_ptr_q == CNT'(DEPTH));

  // A clear on the same cycle as a good byte wins, so that byte is never stored.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    wr_en      = rx_valid && !full && !clr_i;
    if (clr_i) begin
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
    end else if (rx_valid) begin
      if (full) overflow_d = 1'b1;
      else      wr_ptr_d   = wr_ptr_q + CNT'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) ram_q[wr_ptr_q[ADDR-1:0]] <= rx_data;
  end

  always_comb begin
    rd_data_d = '0;
    if (int'(rd_addr_i) < DEPTH) rd_data_d = ram_q[rd_addr_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_data_q <= '0;
    else         rd_data_q <= rd_data_d;
  end

  assign rd_data_o   = rd_data_q;
  assign rx_data_o   = rx_data;
  assign rx_valid_o  = rx_valid;
  assign byte_cnt_o  = wr_ptr_q;
  assign full_o      = full;
  assign overflow_o  = overflow_q;

endmodule
